pipelined_control_unit: RTL and testbench
=========================================

// Module: pipelined_control_unit
// PURPOSE
//  Registered successor to the combinational main/ALU decoder pair. Decodes the D-stage instruction
//  and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers, with stall/flush
//  bubble handling. Detects illegal opcodes and exports load-in-E for the hazard unit.
//  Sits between the IF/ID register and the datapath; the hazard unit drives stall_e/flush_e.
// PARAMETERS
//  ALUCTRL_W  3  ALUControl width; 3 = base set (add/sub/and/or/slt); 4 = adds xor/sll/srl/sra/sltu
//  IMMSRC_W   2  ImmSrc width; 2 = I/S/B; 3 required when CTRL_JUMP_EN defined (adds J/U)
// PORTS
//  clk            in   1          rising-edge clock
//  rst            in   1          asynchronous, active-high reset
//  instr_d        in   32         D-stage instruction (op=[6:0], funct3=[14:12], funct7=[31:25])
//  stall_e        in   1          hold E-stage control; bubble into M
//  flush_e        in   1          load bubble into E (branch taken / load-use)
//  imm_src_d      out  IMMSRC_W   combinational, D stage
//  illegal_d      out  1          combinational, D stage: unsupported opcode/funct
//  alu_control_e  out  ALUCTRL_W  E stage
//  alu_src_e      out  1          E stage
//  branch_e       out  1          E stage
//  jump_e         out  1          E stage; tied 0 without CTRL_JUMP_EN
//  load_e         out  1          E stage: ResultSrc==01 (hazard unit load-use)
//  reg_write_e    out  1          E stage (forwarding)
//  mem_write_m    out  1          M stage
//  result_src_m   out  2          M stage
//  reg_write_m    out  1          M stage
//  result_src_w   out  2          W stage
//  reg_write_w    out  1          W stage
//  illegal_seen   out  1          sticky: set when an illegal instr reaches E; cleared only by rst
// BEHAVIOUR
//  - Reset: every registered output, and illegal_seen, is 0 (all stages hold NOP bubbles).
//  - Decode: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011.
//    ResultSrc: 00 ALU, 01 mem, 10 PC+4.
//  - ALU: add 000, sub 001, and 010, or 011, slt 101. If ALUCTRL_W=4 the codes zero-extend and
//    xor 0100, sll 0110, srl 0111, sra 1000, sltu 1001 are added; with ALUCTRL_W=3 those funct3
//    values are flagged illegal.
//  - sub is selected only for R-type with funct7[5]=1. I-type funct7 is ignored except for shifts.
//  - Illegal instructions enter E as a bubble: reg_write/mem_write/branch/jump = 0.
//  - Latency: D decode -> E after 1 clk, -> M after 2 clk, -> W after 3 clk.
//  - Priority at E, checked in this order:
//      flush_e            -> E bubble; M takes old E
//      stall_e            -> E holds; M takes bubble; W advances normally
//      otherwise          -> all stages shift
//    flush_e wins when both are asserted (E bubble, M still takes old E).
//  - M->W always advances. Back-to-back stalls hold E indefinitely.
//  - rst asserted mid-stream clears all stages on the same edge, with no partial shift.
// CONFIGURATION
//  CTRL_JUMP_EN defined:
//    - jal 1101111 and jalr 1100111 decode with jump_e=1, result_src=10, reg_write=1.
//    - jal: imm_src=J. jalr: alu_src=1.
//    - lui 0110111 decodes as an ALU pass-through of the U-immediate.
//  CTRL_JUMP_EN undefined:
//    - those opcodes are illegal and jump_e is constant 0.
// STRUCTURE
//  - Package ctrl_pkg:
//      - opcode localparams
//      - ALU code localparams for both widths
//      - ResultSrc and ImmSrc encodings
//      - bundle widths per stage
//  - One sub-module: ctrl_decode (combinational instr -> D bundle + illegal).
//  - Top holds the three stage registers and stall/flush muxing.
// TESTING
//  1. rst=1 then release; issue lw x1,0(x2)
//       -> load_e=1 at +1, result_src_m=01 at +2, reg_write_w=1 at +3.
//  2. sub vs add: R-type funct7=0100000
//       -> alu_control_e=001; funct7=0 -> 000; addi with instr[30]=1 -> 000.
//  3. beq then flush_e=1 on the next edge
//       -> E all zero, M holds the beq bundle (branch not written).
//  4. sw with stall_e=1 for 2 cycles
//       -> alu_control_e held; mem_write_m=0 both cycles; mem_write_m=1 after release.
//  5. flush_e and stall_e together -> E bubble; stall ignored.
//  6. Opcode 0000000
//       -> illegal_d=1; at E all writes 0 and illegal_seen=1, stays set.
//     Without CTRL_JUMP_EN, jal -> illegal; with CTRL_JUMP_EN, jal -> jump_e=1, result_src_w=10.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings and stage bundles for the pipelined control unit.
// CTRL_JUMP_EN selects the jal/jalr/lui extension and widens the default ImmSrc.
package ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Base codes fit in 3 bits; the extended set needs the 4-bit ALUControl.
    localparam int ALUCTRL_W_BASE = 3;
    localparam int ALUCTRL_W_EXT  = 4;
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

`ifdef CTRL_JUMP_EN
    localparam int IMMSRC_W_DEF = 3;
`else
    localparam int IMMSRC_W_DEF = 2;
`endif

    typedef struct packed {
        logic [3:0] alu_control;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic [1:0] result_src;
        logic       reg_write;
        logic       mem_write;
    } e_bundle_t;

    typedef struct packed {
        logic       mem_write;
        logic [1:0] result_src;
        logic       reg_write;
    } m_bundle_t;

    typedef struct packed {
        logic [1:0] result_src;
        logic       reg_write;
    } w_bundle_t;

    localparam int E_BUNDLE_W = $bits(e_bundle_t);
    localparam int M_BUNDLE_W = $bits(m_bundle_t);
    localparam int W_BUNDLE_W = $bits(w_bundle_t);

endpackage

// File: rtl/ctrl_decode.sv
// Combinational D-stage decode: instruction -> E-stage control bundle, ImmSrc, illegal flag.
// jal/jalr/lui decode only when CTRL_JUMP_EN is defined.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3
) (
    input  logic [31:0] instr,
    output e_bundle_t   bundle,
    output logic [2:0]  imm_src,
    output logic        illegal
);

    localparam bit WIDE = (ALUCTRL_W >= ALUCTRL_W_EXT);

    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_r;
    logic       shift;
    logic       f7_ok;
    logic [3:0] fn_alu;
    logic       fn_ill;
    logic       unused_fields;

    assign op    = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    assign is_r  = (op == OP_R);
    assign shift = (f3 == 3'b001) || (f3 == 3'b101);
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    // R-type allows funct7[5] only on add/sub and srl/sra; I-type checks funct7 on shifts only.
    assign f7_ok = is_r ? (f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)))
                        : (!shift || f7 == F7_BASE || (f7 == F7_ALT && f3 == 3'b101));

    always_comb begin
        fn_alu = ALU_ADD;
        fn_ill = 1'b0;
        case (f3)
            3'b000: fn_alu = (is_r && f7[5]) ? ALU_SUB : ALU_ADD;
            3'b001: begin fn_alu = ALU_SLL;  fn_ill = !WIDE; end
            3'b010: fn_alu = ALU_SLT;
            3'b011: begin fn_alu = ALU_SLTU; fn_ill = !WIDE; end
            3'b100: begin fn_alu = ALU_XOR;  fn_ill = !WIDE; end
            3'b101: begin fn_alu = f7[5] ? ALU_SRA : ALU_SRL; fn_ill = !WIDE; end
            3'b110: fn_alu = ALU_OR;
            default: fn_alu = ALU_AND;
        endcase
    end

    always_comb begin
        bundle  = '0;
        imm_src = IMM_I;
        illegal = 1'b0;
        case (op)
            OP_LOAD: begin
                illegal           = (f3 != 3'b010);
                bundle.alu_src    = 1'b1;
                bundle.result_src = RES_MEM;
                bundle.reg_write  = 1'b1;
            end
            OP_STORE: begin
                illegal          = (f3 != 3'b010);
                bundle.alu_src   = 1'b1;
                bundle.mem_write = 1'b1;
                imm_src          = IMM_S;
            end
            OP_R: begin
                illegal            = fn_ill || !f7_ok;
                bundle.alu_control = fn_alu;
                bundle.reg_write   = 1'b1;
            end
            OP_IMM: begin
                illegal            = fn_ill || !f7_ok;
                bundle.alu_control = fn_alu;
                bundle.alu_src     = 1'b1;
                bundle.reg_write   = 1'b1;
            end
            OP_BRANCH: begin
                illegal            = (f3 != 3'b000);
                bundle.alu_control = ALU_SUB;
                bundle.branch      = 1'b1;
                imm_src            = IMM_B;
            end
`ifdef CTRL_JUMP_EN
            OP_JAL: begin
                bundle.jump       = 1'b1;
                bundle.result_src = RES_PC4;
                bundle.reg_write  = 1'b1;
                imm_src           = IMM_J;
            end
            OP_JALR: begin
                illegal           = (f3 != 3'b000);
                bundle.jump       = 1'b1;
                bundle.alu_src    = 1'b1;
                bundle.result_src = RES_PC4;
                bundle.reg_write  = 1'b1;
            end
            OP_LUI: begin
                bundle.alu_src   = 1'b1;
                bundle.reg_write = 1'b1;
                imm_src          = IMM_U;
            end
`endif
            default: illegal = 1'b1;
        endcase
        // Illegal instructions travel as bubbles so nothing downstream commits.
        if (illegal) begin
            bundle  = '0;
            imm_src = IMM_I;
        end
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// Registered control path: D decode, then ID/EX, EX/MEM, MEM/WB with stall/flush bubbles.
// CTRL_JUMP_EN enables jal/jalr/lui; otherwise jump_e is constant 0.
module pipelined_control_unit
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3,
    parameter int IMMSRC_W  = IMMSRC_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instr_d,
    input  logic                 stall_e,
    input  logic                 flush_e,
    output logic [IMMSRC_W-1:0]  imm_src_d,
    output logic                 illegal_d,
    output logic [ALUCTRL_W-1:0] alu_control_e,
    output logic                 alu_src_e,
    output logic                 branch_e,
    output logic                 jump_e,
    output logic                 load_e,
    output logic                 reg_write_e,
    output logic                 mem_write_m,
    output logic [1:0]           result_src_m,
    output logic                 reg_write_m,
    output logic [1:0]           result_src_w,
    output logic                 reg_write_w,
    output logic                 illegal_seen
);

    e_bundle_t  d_bundle, e_q;
    m_bundle_t  m_q, e_to_m;
    w_bundle_t  w_q;
    logic [2:0] d_imm;
    logic       unused_ok;

    ctrl_decode #(.ALUCTRL_W(ALUCTRL_W)) u_decode (
        .instr   (instr_d),
        .bundle  (d_bundle),
        .imm_src (d_imm),
        .illegal (illegal_d)
    );

    assign e_to_m = '{mem_write: e_q.mem_write, result_src: e_q.result_src, reg_write: e_q.reg_write};

    // flush outranks stall: E takes a bubble and the old E still drains into M.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q          <= '0;
            m_q          <= '0;
            w_q          <= '0;
            illegal_seen <= 1'b0;
        end else begin
            w_q <= '{result_src: m_q.result_src, reg_write: m_q.reg_write};
            if (flush_e) begin
                e_q <= '0;
                m_q <= e_to_m;
            end else if (stall_e) begin
                m_q <= '0;
            end else begin
                e_q <= d_bundle;
                m_q <= e_to_m;
            end
            if (!flush_e && !stall_e && illegal_d)
                illegal_seen <= 1'b1;
        end
    end

    assign imm_src_d     = d_imm[IMMSRC_W-1:0];
    assign alu_control_e = e_q.alu_control[ALUCTRL_W-1:0];
    assign alu_src_e     = e_q.alu_src;
    assign branch_e      = e_q.branch;
    assign load_e        = (e_q.result_src == RES_MEM);
    assign reg_write_e   = e_q.reg_write;
    assign mem_write_m   = m_q.mem_write;
    assign result_src_m  = m_q.result_src;
    assign reg_write_m   = m_q.reg_write;
    assign result_src_w  = w_q.result_src;
    assign reg_write_w   = w_q.reg_write;
`ifdef CTRL_JUMP_EN
    assign jump_e        = e_q.jump;
`else
    assign jump_e        = 1'b0;
`endif
    assign unused_ok     = ^{e_q, d_imm};

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: decode table, directed hazard sequences, random vs model.
module tb_pipelined_control_unit;

    localparam int ALUW = 3;
`ifdef CTRL_JUMP_EN
    localparam int IMMW = 3;
`else
    localparam int IMMW = 2;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     instr_d;
    logic            stall_e, flush_e;
    logic [IMMW-1:0] imm_src_d;
    logic            illegal_d;
    logic [ALUW-1:0] alu_control_e;
    logic            alu_src_e, branch_e, jump_e, load_e, reg_write_e;
    logic            mem_write_m, reg_write_m, reg_write_w, illegal_seen;
    logic [1:0]      result_src_m, result_src_w;

    pipelined_control_unit dut (
        .clk(clk), .rst(rst), .instr_d(instr_d), .stall_e(stall_e), .flush_e(flush_e),
        .imm_src_d(imm_src_d), .illegal_d(illegal_d), .alu_control_e(alu_control_e),
        .alu_src_e(alu_src_e), .branch_e(branch_e), .jump_e(jump_e), .load_e(load_e),
        .reg_write_e(reg_write_e), .mem_write_m(mem_write_m), .result_src_m(result_src_m),
        .reg_write_m(reg_write_m), .result_src_w(result_src_w), .reg_write_w(reg_write_w),
        .illegal_seen(illegal_seen)
    );

    always #5 clk = ~clk;

    typedef enum {M_ILL, M_LW, M_SW, M_BEQ, M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_XOR,
                  M_SLL, M_SRL, M_SRA, M_SLTU, M_JAL, M_JALR, M_LUI} mn_t;

    typedef struct packed {
        logic [3:0] alu;
        logic       asrc, br, jmp;
        logic [1:0] rs;
        logic       rw, mw, ill;
        logic [2:0] imm;
    } ctl_t;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  imm;
        logic        ill;
        logic [3:0]  alu;
        logic        asrc, br, load, rw;
    } vec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    ctl_t me, mm, mw;
    logic seen;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
        return {f7, 5'd3, 5'd2, f3, 5'd1, op};
    endfunction

    function automatic mn_t alu_mn(input logic [2:0] f3, input logic [6:0] f7, input logic immf);
        if (f3 == 3'd1) return (f7 == 7'h00) ? M_SLL : M_ILL;
        if (f3 == 3'd5) return (f7 == 7'h00) ? M_SRL : (f7 == 7'h20) ? M_SRA : M_ILL;
        if (!immf && f7 != 7'h00) return (f7 == 7'h20 && f3 == 3'd0) ? M_SUB : M_ILL;
        case (f3)
            3'd0: return M_ADD;
            3'd2: return M_SLT;
            3'd3: return M_SLTU;
            3'd4: return M_XOR;
            3'd6: return M_OR;
            default: return M_AND;
        endcase
    endfunction

    // Reference decode: name the instruction first, then look up its control word.
    function automatic ctl_t ref_dec(input logic [31:0] i);
        mn_t  m = M_ILL;
        logic immf = 1'b0;
        ctl_t c = '0;
        case (i[6:0])
            7'b0000011: if (i[14:12] == 3'd2) m = M_LW;
            7'b0100011: if (i[14:12] == 3'd2) m = M_SW;
            7'b1100011: if (i[14:12] == 3'd0) m = M_BEQ;
            7'b0110011: m = alu_mn(i[14:12], i[31:25], 1'b0);
            7'b0010011: begin immf = 1'b1; m = alu_mn(i[14:12], i[31:25], 1'b1); end
`ifdef CTRL_JUMP_EN
            7'b1101111: m = M_JAL;
            7'b1100111: if (i[14:12] == 3'd0) m = M_JALR;
            7'b0110111: m = M_LUI;
`endif
            default: m = M_ILL;
        endcase
        if (ALUW == 3 && (m == M_XOR || m == M_SLL || m == M_SRL || m == M_SRA || m == M_SLTU))
            m = M_ILL;
        case (m)
            M_ILL:  c.ill = 1'b1;
            M_LW:   begin c.asrc = 1; c.rs = 2'b01; c.rw = 1; end
            M_SW:   begin c.asrc = 1; c.mw = 1; c.imm = 3'd1; end
            M_BEQ:  begin c.br = 1; c.alu = 4'd1; c.imm = 3'd2; end
            M_JAL:  begin c.jmp = 1; c.rs = 2'b10; c.rw = 1; c.imm = 3'd3; end
            M_JALR: begin c.jmp = 1; c.rs = 2'b10; c.rw = 1; c.asrc = 1; end
            M_LUI:  begin c.asrc = 1; c.rw = 1; c.imm = 3'd4; end
            default: begin
                c.rw = 1; c.asrc = immf;
                case (m)
                    M_SUB:  c.alu = 4'd1;
                    M_AND:  c.alu = 4'd2;
                    M_OR:   c.alu = 4'd3;
                    M_XOR:  c.alu = 4'd4;
                    M_SLT:  c.alu = 4'd5;
                    M_SLL:  c.alu = 4'd6;
                    M_SRL:  c.alu = 4'd7;
                    M_SRA:  c.alu = 4'd8;
                    M_SLTU: c.alu = 4'd9;
                    default: c.alu = 4'd0;
                endcase
            end
        endcase
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        me = '0; mm = '0; mw = '0; seen = 1'b0;
    endtask

    task automatic check_regs();
        chk("alu_control_e", 32'(alu_control_e), 32'(me.alu));
        chk("alu_src_e",     32'(alu_src_e),     32'(me.asrc));
        chk("branch_e",      32'(branch_e),      32'(me.br));
        chk("jump_e",        32'(jump_e),        32'(me.jmp));
        chk("load_e",        32'(load_e),        32'(me.rs == 2'b01));
        chk("reg_write_e",   32'(reg_write_e),   32'(me.rw));
        chk("mem_write_m",   32'(mem_write_m),   32'(mm.mw));
        chk("result_src_m",  32'(result_src_m),  32'(mm.rs));
        chk("reg_write_m",   32'(reg_write_m),   32'(mm.rw));
        chk("result_src_w",  32'(result_src_w),  32'(mw.rs));
        chk("reg_write_w",   32'(reg_write_w),   32'(mw.rw));
        chk("illegal_seen",  32'(illegal_seen),  32'(seen));
    endtask

    // One clock: drive at negedge, check decode, advance the model at posedge, check at negedge.
    task automatic cyc(input logic [31:0] i, input logic s, input logic f);
        ctl_t d;
        instr_d = i; stall_e = s; flush_e = f;
        d = ref_dec(i);
        #1;
        chk("imm_src_d", 32'(imm_src_d), 32'(d.imm[IMMW-1:0]));
        chk("illegal_d", 32'(illegal_d), 32'(d.ill));
        @(posedge clk);
        if (rst) model_clear();
        else begin
            mw = mm;
            if (f)      begin mm = me; me = '0; end
            else if (s) mm = '0;
            else        begin mm = me; me = d; end
            if (!f && !s && d.ill) seen = 1'b1;
        end
        @(negedge clk);
        check_regs();
    endtask

    vec_t tbl[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl.push_back('{mk(7'h00, 3'd2, 7'b0000011), 3'd0, 0, 4'd0, 1, 0, 1, 1}); // lw
        tbl.push_back('{mk(7'h00, 3'd2, 7'b0100011), 3'd1, 0, 4'd0, 1, 0, 0, 0}); // sw
        tbl.push_back('{mk(7'h00, 3'd0, 7'b0110011), 3'd0, 0, 4'd0, 0, 0, 0, 1}); // add
        tbl.push_back('{mk(7'h20, 3'd0, 7'b0110011), 3'd0, 0, 4'd1, 0, 0, 0, 1}); // sub
        tbl.push_back('{mk(7'h20, 3'd0, 7'b0010011), 3'd0, 0, 4'd0, 1, 0, 0, 1}); // addi, instr[30]=1
        tbl.push_back('{mk(7'h00, 3'd7, 7'b0110011), 3'd0, 0, 4'd2, 0, 0, 0, 1}); // and
        tbl.push_back('{mk(7'h00, 3'd6, 7'b0110011), 3'd0, 0, 4'd3, 0, 0, 0, 1}); // or
        tbl.push_back('{mk(7'h00, 3'd2, 7'b0110011), 3'd0, 0, 4'd5, 0, 0, 0, 1}); // slt
        tbl.push_back('{mk(7'h15, 3'd2, 7'b0010011), 3'd0, 0, 4'd5, 1, 0, 0, 1}); // slti
        tbl.push_back('{mk(7'h00, 3'd6, 7'b0010011), 3'd0, 0, 4'd3, 1, 0, 0, 1}); // ori
        tbl.push_back('{mk(7'h00, 3'd0, 7'b1100011), 3'd2, 0, 4'd1, 0, 1, 0, 0}); // beq
        tbl.push_back('{mk(7'h00, 3'd4, 7'b0110011), 3'd0, 1, 4'd0, 0, 0, 0, 0}); // xor: base set only
        tbl.push_back('{mk(7'h20, 3'd2, 7'b0110011), 3'd0, 1, 4'd0, 0, 0, 0, 0}); // bad funct7
        tbl.push_back('{mk(7'h00, 3'd0, 7'b0000011), 3'd0, 1, 4'd0, 0, 0, 0, 0}); // lb unsupported
        tbl.push_back('{32'h0000_0000,               3'd0, 1, 4'd0, 0, 0, 0, 0}); // opcode 0
`ifdef CTRL_JUMP_EN
        tbl.push_back('{mk(7'h00, 3'd0, 7'b1101111), 3'd3, 0, 4'd0, 0, 0, 0, 1}); // jal
`else
        tbl.push_back('{mk(7'h00, 3'd0, 7'b1101111), 3'd0, 1, 4'd0, 0, 0, 0, 0}); // jal illegal
`endif

        rst = 1'b1; instr_d = NOP; stall_e = 1'b0; flush_e = 1'b0;
        model_clear();
        @(negedge clk); @(negedge clk);
        check_regs();
        rst = 1'b0;

        // lw propagation latency
        cyc(mk(7'h00, 3'd2, 7'b0000011), 0, 0);
        chk("t1_load_e", 32'(load_e), 1);
        cyc(NOP, 0, 0);
        chk("t1_result_src_m", 32'(result_src_m), 2'b01);
        cyc(NOP, 0, 0);
        chk("t1_reg_write_w", 32'(reg_write_w), 1);

        // beq followed by flush
        cyc(mk(7'h00, 3'd0, 7'b1100011), 0, 0);
        chk("t3_branch_e", 32'(branch_e), 1);
        cyc(NOP, 0, 1);
        chk("t3_branch_e_flushed", 32'(branch_e), 0);
        chk("t3_reg_write_e_flushed", 32'(reg_write_e), 0);
        chk("t3_reg_write_m_beq", 32'(reg_write_m), 0);

        // sw held two cycles by stall
        cyc(mk(7'h00, 3'd2, 7'b0100011), 0, 0);
        for (int k = 0; k < 2; k++) begin
            cyc(mk(7'h20, 3'd0, 7'b0110011), 1, 0);
            chk("t4_alu_control_e_held", 32'(alu_control_e), 0);
            chk("t4_alu_src_e_held", 32'(alu_src_e), 1);
            chk("t4_mem_write_m_bubble", 32'(mem_write_m), 0);
        end
        cyc(mk(7'h20, 3'd0, 7'b0110011), 0, 0);
        chk("t4_mem_write_m_release", 32'(mem_write_m), 1);
        chk("t4_alu_control_e_sub", 32'(alu_control_e), 1);

        // flush and stall together
        cyc(mk(7'h00, 3'd7, 7'b0110011), 1, 1);
        chk("t5_reg_write_e", 32'(reg_write_e), 0);
        chk("t5_reg_write_m", 32'(reg_write_m), 1);
        cyc(mk(7'h00, 3'd7, 7'b0110011), 0, 0);
        chk("t5_alu_control_e_and", 32'(alu_control_e), 2);

        // illegal opcode
        chk("t6_illegal_seen_clear", 32'(illegal_seen), 0);
        cyc(32'h0, 0, 0);
        chk("t6_illegal_d", 32'(illegal_d), 1);
        chk("t6_reg_write_e", 32'(reg_write_e), 0);
        chk("t6_illegal_seen", 32'(illegal_seen), 1);
        cyc(NOP, 0, 0);
        chk("t6_illegal_seen_sticky", 32'(illegal_seen), 1);

        foreach (tbl[k]) begin
            cyc(tbl[k].instr, 0, 0);
            chk($sformatf("tbl%0d_imm_src_d", k), 32'(imm_src_d), 32'(tbl[k].imm[IMMW-1:0]));
            chk($sformatf("tbl%0d_illegal_d", k), 32'(illegal_d), 32'(tbl[k].ill));
            chk($sformatf("tbl%0d_alu_control_e", k), 32'(alu_control_e), 32'(tbl[k].alu));
            chk($sformatf("tbl%0d_alu_src_e", k), 32'(alu_src_e), 32'(tbl[k].asrc));
            chk($sformatf("tbl%0d_branch_e", k), 32'(branch_e), 32'(tbl[k].br));
            chk($sformatf("tbl%0d_load_e", k), 32'(load_e), 32'(tbl[k].load));
            chk($sformatf("tbl%0d_reg_write_e", k), 32'(reg_write_e), 32'(tbl[k].rw));
        end

        // jal through to W
        cyc(mk(7'h00, 3'd0, 7'b1101111), 0, 0);
`ifdef CTRL_JUMP_EN
        chk("jal_jump_e", 32'(jump_e), 1);
        cyc(NOP, 0, 0);
        cyc(NOP, 0, 0);
        chk("jal_result_src_w", 32'(result_src_w), 2'b10);
`else
        chk("jal_illegal_d", 32'(illegal_d), 1);
        chk("jal_jump_e", 32'(jump_e), 0);
`endif

        // asynchronous reset mid-stream
        cyc(mk(7'h00, 3'd2, 7'b0000011), 0, 0);
        cyc(mk(7'h00, 3'd2, 7'b0100011), 0, 0);
        rst = 1'b1;
        model_clear();
        #1;
        check_regs();
        @(posedge clk); @(negedge clk);
        check_regs();
        rst = 1'b0;

        for (int n = 0; n < 400; n++) begin
            logic [6:0] op;
            logic [6:0] f7;
            logic [31:0] ins;
            case ($urandom_range(8))
                0: op = 7'b0000011;
                1: op = 7'b0100011;
                2, 3: op = 7'b0110011;
                4, 5: op = 7'b0010011;
                6: op = 7'b1100011;
                7: op = ($urandom_range(1) == 1) ? 7'b1101111 : 7'b0110111;
                default: op = 7'($urandom);
            endcase
            case ($urandom_range(3))
                0, 1: f7 = 7'h00;
                2: f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            ins = {f7, 10'($urandom), 3'($urandom), 5'($urandom), op};
            rst = ($urandom_range(99) == 0);
            if (rst) model_clear();
            cyc(ins, ($urandom_range(4) == 0), ($urandom_range(6) == 0));
            rst = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
